evm_ballot_unit: RTL

//  Ballot capture core of the EVM, directly downstream of the clock generator; runs on its clk output.
//  - Debounces candidate push-buttons.
//  - Accepts exactly one vote per ballot enable from the polling officer.
//  - Locks out further input until release plus a lock period.
//  - Keeps per-candidate tallies readable through a select port.

---
 rtl/evm_ballot_unit.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/evm_ballot_unit.sv
// evm_ballot_unit: ballot capture core of the EVM.
// Conditions candidate push-buttons (2-FF sync + debounce), accepts exactly one
// vote per ballot enable, locks out input for a minimum period and until all
// buttons are released, and keeps per-candidate tallies with registered readback.
// Build option: define EVM_TALLY_SAT_EN for saturating tallies with a sticky
// sat flag; when undefined, tallies wrap and sat is tied low.
module evm_ballot_unit #(
    parameter int NUM_CAND    = 4,
    parameter int CNT_W       = 8,
    parameter int DEB_CYCLES  = 4,
    parameter int LOCK_CYCLES = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ballot_en,
    input  logic [NUM_CAND-1:0]         btn,
    input  logic [$clog2(NUM_CAND)-1:0] tally_sel,
    output logic                        ready,
    output logic                        busy,
    output logic                        vote_valid,
    output logic [$clog2(NUM_CAND)-1:0] vote_idx,
    output logic [CNT_W-1:0]            tally_out,
    output logic                        sat
);

    localparam int SEL_W  = $clog2(NUM_CAND);
    localparam int RC_W   = $clog2(NUM_CAND + 1);
    localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
    localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);
    localparam logic [RC_W-1:0]   ONE_RISE  = RC_W'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_CAST  = 2'd2;
    localparam logic [1:0] S_LOCK  = 2'd3;

    logic [NUM_CAND-1:0] sync_p0;
    logic [NUM_CAND-1:0] sync_p1;
    logic [NUM_CAND-1:0] deb;
    logic [NUM_CAND-1:0] deb_d;
    logic [DEB_W-1:0]    deb_cnt [NUM_CAND];

    logic [NUM_CAND-1:0] rise;
    logic [SEL_W-1:0]    rise_idx;
    logic [RC_W-1:0]     rise_cnt;

    logic [1:0]          state;
    logic [SEL_W-1:0]    cast_idx;
    logic [LOCK_W-1:0]   lock_cnt;
    logic [CNT_W-1:0]    tally [NUM_CAND];

    // Two-flop synchronizer for the asynchronous buttons
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= btn;
            sync_p1 <= sync_p0;
        end
    end

    // Debounce: level flips after DEB_CYCLES consecutive differing samples; deb_d keeps last level for edge detect
    always_ff @(posedge clk) begin
        if (rst) begin
            deb   <= '0;
            deb_d <= '0;
            for (int i = 0; i < NUM_CAND; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            deb_d <= deb;
            for (int i = 0; i < NUM_CAND; i++) begin
                if (sync_p1[i] != deb[i]) begin
                    if (deb_cnt[i] == DEB_LAST) begin
                        deb[i]     <= ~deb[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 1'b1;
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    assign rise = deb & ~deb_d;

    // Count simultaneous debounced rising edges and locate the (single) one
    always_comb begin
        rise_idx = '0;
        rise_cnt = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (rise[i]) begin
                rise_idx = SEL_W'(i);
                rise_cnt = rise_cnt + 1'b1;
            end
        end
    end

    // Ballot state machine: IDLE -> ARMED -> CAST -> LOCK -> IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cast_idx   <= '0;
            lock_cnt   <= '0;
            vote_valid <= 1'b0;
            vote_idx   <= '0;
        end else begin
            vote_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ballot_en) begin
                        state <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    // Edges only: a button held on entry never produces a rise until re-pressed
                    if (rise_cnt == ONE_RISE) begin
                        cast_idx <= rise_idx;
                        state    <= S_CAST;
                    end
                end
                S_CAST: begin
                    vote_valid <= 1'b1;
                    vote_idx   <= cast_idx;
                    lock_cnt   <= '0;
                    state      <= S_LOCK;
                end
                S_LOCK: begin
                    // Counter parks at its last value so held buttons extend the lockout indefinitely
                    if (lock_cnt == LOCK_LAST) begin
                        if (deb == '0) begin
                            state <= S_IDLE;
                        end
                    end else begin
                        lock_cnt <= lock_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign ready = (state == S_ARMED);
    assign busy  = (state == S_CAST) || (state == S_LOCK);

`ifdef EVM_TALLY_SAT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_PEN = CNT_MAX - 1'b1;

    // Saturating tally update in the cast cycle; sat latches on the vote that reaches max
    always_ff @(posedge clk) begin
        if (rst) begin
            sat <= 1'b0;
            for (int i = 0; i < NUM_CAND; i++) begin
                tally[i] <= '0;
            end
        end else if ((state == S_CAST) && (tally[cast_idx] != CNT_MAX)) begin
            tally[cast_idx] <= tally[cast_idx] + 1'b1;
            if (tally[cast_idx] == CNT_PEN) begin
                sat <= 1'b1;
            end
        end
    end
`else
    // Wrapping tally update in the cast cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CAND; i++) begin
                tally[i] <= '0;
            end
        end else if (state == S_CAST) begin
            tally[cast_idx] <= tally[cast_idx] + 1'b1;
        end
    end

    assign sat = 1'b0;
`endif

    // Registered tally readback; out-of-range selects read as zero
    always_ff @(posedge clk) begin
        if (rst) begin
            tally_out <= '0;
        end else if (int'(tally_sel) < NUM_CAND) begin
            tally_out <= tally[tally_sel];
        end else begin
            tally_out <= '0;
        end
    end

endmodule
